watchdog_kicker: RTL and testbench
==================================

# watchdog_kicker

Transmit side of the watchdog sense interface. Monitors up to NUM_SOURCES heartbeat signals from clock subsystems (time counter, display mux, button scanner, …). Drives a one-cycle `kick` into a watchdog sense input once per kick period, but only if every enabled source showed activity during that period. Consecutive failures make it deliberately withhold kicks, so the downstream watchdog barks.

## Interface
- `NUM_SOURCES`, 4, number of heartbeat inputs (≥1)
- `KICK_PERIOD`, 8, window length in `tick` strobes (≥1)
- `MAX_MISSES`, 2, consecutive failed windows before starving (≥1)

- `clk` in 1: single clock, all logic on posedge
- `reset_n` in 1: asynchronous, active-low reset
- `tick` in 1: window-advance strobe (one `clk` cycle wide)
- `enable` in 1: kicker active when high
- `heartbeat` in NUM_SOURCES: per-source level; any toggle = activity
- `source_mask` in NUM_SOURCES: 1 = source monitored, 0 = ignored
- `kick` out 1: one-cycle pulse to watchdog sense input
- `stalled_mask` out NUM_SOURCES: monitored sources silent in last evaluated window
- `miss_count` out $clog2(MAX_MISSES+1): consecutive failed windows
- `starving` out 1: high while kicks are withheld

## Operation
- **Activity detect**
  - `hb_q` registers `heartbeat` every cycle; `edge = heartbeat ^ hb_q`.
  - `seen[i]` is sticky: it sets on `edge[i]`.
  - `hb_q` resets to 0, so a source high out of reset counts as activity.
- **States:** IDLE, RUN, STARVE.
  - IDLE: `period_cnt`, `seen`, `miss_count` and `stalled_mask` are held at 0; no kicks. `enable`=1 → RUN.
  - RUN: each `tick` increments `period_cnt`. A `tick` with `period_cnt == KICK_PERIOD-1` is an evaluation; `period_cnt` then wraps to 0.
  - Evaluation: `ok = &((seen | edge) | ~source_mask)`.
    - ok → pulse `kick`, set `miss_count`=0 and `stalled_mask`=0.
    - not ok → set `stalled_mask = ~(seen|edge) & source_mask`, increment `miss_count`; if the new value equals MAX_MISSES → STARVE.
    - Either way, `seen` clears; the evaluation-cycle edge is consumed.
  - STARVE: no kicks; `period_cnt` is frozen; `stalled_mask` and `miss_count` are frozen. Exit only via `enable`=0 (→ IDLE) or reset.
  - `enable`=0 in any state → IDLE next cycle, with the clears applied.
- **Boundary cases**
  - Edge on the evaluation cycle counts for the closing window.
  - `source_mask`=0 (all bits) → every evaluation is ok.
  - `tick` while in IDLE is ignored.
  - `source_mask` is sampled at the evaluation only.
- **Widths**
  - `period_cnt` width is max(1, $clog2(KICK_PERIOD)); it never exceeds KICK_PERIOD-1.
  - `miss_count` saturates at MAX_MISSES.

## Timing
- **Reset:** all outputs 0; state IDLE; `period_cnt`, `seen`, `hb_q` at 0. Assertion takes effect immediately (async); release is synchronous to `clk`.
- **Evaluation at edge E:**
  - `kick`, `stalled_mask`, `miss_count` and `starving` are registered and update at E+1.
  - `kick` is exactly one cycle wide.
- **Period:** with `tick` every cycle, kicks are KICK_PERIOD cycles apart.
- **Enable:** `enable` falling at E forces `kick`=0 and `starving`=0 from E+1.
- **Reset mid-window:** the partial window is discarded; no kick is issued.

## Structure
- Shared package/include `watchdog_defs` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, STARVE=2'd2);
  - a width helper for counter sizing.
- Sub-module `heartbeat_activity`, instantiated once, vectorised over NUM_SOURCES. It owns `hb_q`, `edge` and `seen`, with inputs `clear` and `clr_all`.
- The top level holds the FSM, `period_cnt`, `miss_count` and the output registers.

## Test plan
Config: NUM_SOURCES=4, KICK_PERIOD=4, MAX_MISSES=2, `tick`=1 every cycle, `source_mask`=4'hF unless stated.

- **Reset:** `reset_n`=0 mid-run → `kick`=0, `stalled_mask`=0, `miss_count`=0, `starving`=0 immediately. Release with `enable`=0 → stays IDLE, no kicks.
- **All healthy:** `enable`=1, all heartbeats toggle every 2 cycles → `kick` pulses every 4 cycles, 1 cycle wide; `miss_count`=0.
- **Single miss, recovery:** source 2 held static for one window → no kick at that evaluation; `stalled_mask`=4'b0100, `miss_count`=1. Next window healthy → kick, `stalled_mask`=0, `miss_count`=0.
- **Starve:** source 2 static for two windows → `starving`=1 after the 2nd evaluation, `miss_count`=2, no kicks for 20+ cycles. Toggle `enable` 1→0→1 → `starving`=0 and kicks resume after 4 cycles.
- **Mask and late edge:**
  - `source_mask`=4'b1011 with source 2 static → kicks continue.
  - Source 0's only toggle lands on the evaluation cycle → still kicks; the next window needs a fresh toggle.

Source files
------------

// File: rtl/watchdog_defs.sv
// Shared definitions for the watchdog kicker: FSM encoding and
// counter sizing helper.
package watchdog_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STARVE = 2'd2
    } wd_state_e;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/watchdog_kicker_if.sv
// Sense-side bundle between the heartbeat sources and the kicker.
// The kicker is the slave; whoever feeds it is the master.
interface watchdog_kicker_if #(
    parameter int NUM_SOURCES = 4,
    parameter int MAX_MISSES  = 2
);
    localparam int MW = $clog2(MAX_MISSES + 1);

    logic                   tick;
    logic                   enable;
    logic [NUM_SOURCES-1:0] heartbeat;
    logic [NUM_SOURCES-1:0] source_mask;
    logic                   kick;
    logic [NUM_SOURCES-1:0] stalled_mask;
    logic [MW-1:0]          miss_count;
    logic                   starving;

    modport master (
        output tick, enable, heartbeat, source_mask,
        input  kick, stalled_mask, miss_count, starving
    );

    modport slave (
        input  tick, enable, heartbeat, source_mask,
        output kick, stalled_mask, miss_count, starving
    );
endinterface

// File: rtl/heartbeat_activity.sv
// Per-source toggle detector with sticky "seen" flags that the
// kicker clears at each evaluation or while idle.
module heartbeat_activity #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] heartbeat,
    input  logic         clear,
    input  logic         clr_all,
    output logic [N-1:0] hb_edge,
    output logic [N-1:0] seen
);
    logic [N-1:0] hb_q, hb_d;
    logic [N-1:0] seen_q, seen_d;

    // hb_q resets low, so a source already high counts as a toggle.
    always_comb begin
        hb_d    = heartbeat;
        hb_edge = heartbeat ^ hb_q;
        seen_d  = (clear || clr_all) ? '0 : (seen_q | hb_edge);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_q   <= '0;
            seen_q <= '0;
        end else begin
            hb_q   <= hb_d;
            seen_q <= seen_d;
        end
    end

    assign seen = seen_q;
endmodule

// File: rtl/watchdog_kicker.sv
// Kicks the downstream watchdog once per window when every monitored
// heartbeat toggled; withholds kicks after repeated failed windows.
module watchdog_kicker
    import watchdog_defs::*;
#(
    parameter int NUM_SOURCES = 4,
    parameter int KICK_PERIOD = 8,
    parameter int MAX_MISSES  = 2
) (
    input logic               clk,
    input logic               reset_n,
    watchdog_kicker_if.slave  bus
);
    localparam int N  = NUM_SOURCES;
    localparam int PW = cnt_width(KICK_PERIOD);
    localparam int MW = $clog2(MAX_MISSES + 1);

    wd_state_e       state_q, state_d;
    logic [PW-1:0]   period_q, period_d;
    logic [MW-1:0]   miss_q, miss_d, miss_inc;
    logic [N-1:0]    stalled_q, stalled_d;
    logic            kick_q, kick_d;
    logic            starv_q, starv_d;
    logic            clear, clr_all, ok;
    logic [N-1:0]    hb_edge, seen, act;

    heartbeat_activity #(.N(N)) u_act (
        .clk       (clk),
        .rst_n     (reset_n),
        .heartbeat (bus.heartbeat),
        .clear     (clear),
        .clr_all   (clr_all),
        .hb_edge   (hb_edge),
        .seen      (seen)
    );

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        miss_d    = miss_q;
        stalled_d = stalled_q;
        kick_d    = 1'b0;
        starv_d   = 1'b0;
        clear     = 1'b0;
        clr_all   = 1'b0;
        // The evaluation-cycle edge still belongs to the closing window.
        act       = seen | hb_edge;
        ok        = &(act | ~bus.source_mask);
        miss_inc  = (miss_q == MW'(MAX_MISSES)) ? miss_q
                                                 : miss_q + MW'(1);
        if (!bus.enable) begin
            state_d   = ST_IDLE;
            period_d  = '0;
            miss_d    = '0;
            stalled_d = '0;
            clr_all   = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.tick) begin
                        if (period_q == PW'(KICK_PERIOD - 1)) begin
                            period_d = '0;
                            clear    = 1'b1;
                            if (ok) begin
                                kick_d    = 1'b1;
                                miss_d    = '0;
                                stalled_d = '0;
                            end else begin
                                stalled_d = ~act & bus.source_mask;
                                miss_d    = miss_inc;
                                if (miss_inc == MW'(MAX_MISSES)) begin
                                    state_d = ST_STARVE;
                                    starv_d = 1'b1;
                                end
                            end
                        end else begin
                            period_d = period_q + PW'(1);
                        end
                    end
                end
                ST_STARVE: begin
                    starv_d = 1'b1;
                end
                default: begin
                    state_d   = ST_RUN;
                    period_d  = '0;
                    miss_d    = '0;
                    stalled_d = '0;
                    clr_all   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            miss_q    <= '0;
            stalled_q <= '0;
            kick_q    <= 1'b0;
            starv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            miss_q    <= miss_d;
            stalled_q <= stalled_d;
            kick_q    <= kick_d;
            starv_q   <= starv_d;
        end
    end

    assign bus.kick         = kick_q;
    assign bus.stalled_mask = stalled_q;
    assign bus.miss_count   = miss_q;
    assign bus.starving     = starv_q;
endmodule

// File: tb/tb_watchdog_kicker.sv
// Directed bench for watchdog_kicker: KICK_PERIOD=4, MAX_MISSES=2,
// tick every cycle, each window stepped edge by edge.
module tb_watchdog_kicker;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    watchdog_kicker_if #(.NUM_SOURCES(4), .MAX_MISSES(2)) bus ();

    watchdog_kicker #(
        .NUM_SOURCES(4),
        .KICK_PERIOD(4),
        .MAX_MISSES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic k,
                           input logic [3:0] s, input logic [1:0] m,
                           input logic st);
        chk({tag, ".kick"},     8'(bus.kick),         8'(k));
        chk({tag, ".stalled"},  8'(bus.stalled_mask), 8'(s));
        chk({tag, ".miss"},     8'(bus.miss_count),   8'(m));
        chk({tag, ".starving"}, 8'(bus.starving),     8'(st));
    endtask

    // One 4-edge window; toggles ta after edge 1 and tb_ after edge 3,
    // so tb_ lands on the evaluation cycle itself.
    task automatic window(input string tag, input logic [3:0] ta,
                          input logic [3:0] tb_, input logic ek,
                          input logic [3:0] es, input logic [1:0] em,
                          input logic est);
        for (int l = 0; l < 4; l++) begin
            if (l == 1) bus.heartbeat = bus.heartbeat ^ ta;
            if (l == 3) bus.heartbeat = bus.heartbeat ^ tb_;
            step();
            if (l < 3)
                chk({tag, ".mid"}, 8'(bus.kick), 8'h0);
            else
                chk_out(tag, ek, es, em, est);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.tick        = 1'b1;
        bus.enable      = 1'b0;
        bus.heartbeat   = 4'h0;
        bus.source_mask = 4'hF;
        #1;
        chk_out("reset", 1'b0, 4'h0, 2'd0, 1'b0);
        step();
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bus.heartbeat = bus.heartbeat ^ 4'hF;
            step();
            chk("idle_dis", 8'(bus.kick), 8'h0);
        end
        chk("idle_miss", 8'(bus.miss_count), 8'h0);

        bus.enable = 1'b1;
        step();
        chk("enter_run", 8'(bus.kick), 8'h0);
        window("healthy1", 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);
        window("healthy2", 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);
        window("miss1",    4'hB, 4'hB, 1'b0, 4'h4, 2'd1, 1'b0);
        window("recover",  4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);
        window("missA",    4'hB, 4'hB, 1'b0, 4'h4, 2'd1, 1'b0);
        window("missB",    4'hB, 4'hB, 1'b0, 4'h4, 2'd2, 1'b1);
        for (int w = 0; w < 6; w++)
            window("starve", 4'hF, 4'hF, 1'b0, 4'h4, 2'd2, 1'b1);

        bus.enable = 1'b0;
        step();
        chk_out("disable", 1'b0, 4'h0, 2'd0, 1'b0);
        bus.enable = 1'b1;
        step();
        chk("reenable", 8'(bus.kick), 8'h0);
        window("resume", 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);

        bus.source_mask = 4'hB;
        window("masked1", 4'hB, 4'hB, 1'b1, 4'h0, 2'd0, 1'b0);
        window("masked2", 4'hB, 4'hB, 1'b1, 4'h0, 2'd0, 1'b0);
        bus.source_mask = 4'hF;

        window("late",     4'hE, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);
        window("consumed", 4'hE, 4'hE, 1'b0, 4'h1, 2'd1, 1'b0);
        window("fresh",    4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);

        bus.source_mask = 4'h0;
        window("nomask", 4'h0, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0);
        bus.source_mask = 4'hF;

        window("pre_rst", 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rst_kick", 8'(bus.kick), 8'h0);
        step();
        reset_n = 1'b1;
        step();
        window("post_rst", 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);

        window("pre_rst2", 4'hB, 4'hB, 1'b0, 4'h4, 2'd1, 1'b0);
        bus.heartbeat = bus.heartbeat ^ 4'hF;
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 4'h0, 2'd0, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        chk("rst_idle", 8'(bus.kick), 8'h0);
        window("after_partial", 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
